// File: rtl/fifo_pkg.sv
// Shared sizing helpers and error-flag bit positions for the timed-release FIFO.
package fifo_pkg;

    localparam int unsigned ERR_OVF = 0;
    localparam int unsigned ERR_UDF = 1;
    localparam int unsigned ERR_W   = 2;

    // Occupancy needs one extra bit so that a full FIFO is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_entry_timer.sv
// One FIFO slot's release timer: deadline register, sticky mature bit, equality compare.
module fifo_entry_timer #(
    parameter int unsigned DELAY_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DELAY_WIDTH-1:0] i_ts,
    input  logic                   i_wr,
    input  logic [DELAY_WIDTH-1:0] i_delay,
    input  logic                   i_pop,
    output logic                   o_ready_c
);

    logic [DELAY_WIDTH-1:0] r_deadline;
    logic                   r_mature;
    logic                   r_valid;
    logic                   w_hit;

    // Exact-match compare each cycle, so a deadline past the ts wrap is never skipped.
    assign w_hit     = (i_ts == r_deadline);
    assign o_ready_c = r_mature | w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deadline <= '0;
            r_mature   <= 1'b0;
            r_valid    <= 1'b0;
        end else if (i_wr) begin
            r_deadline <= i_ts + i_delay;
            r_mature   <= (i_delay == '0);
            r_valid    <= 1'b1;
        end else if (i_pop) begin
            r_mature   <= 1'b0;
            r_valid    <= 1'b0;
        end else if (r_valid && !r_mature && w_hit) begin
            r_mature   <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_timed_release.sv
// In-order FIFO whose words become readable only after a per-word release delay.
module fifo_timed_release import fifo_pkg::*; #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DELAY_WIDTH = 8,
    parameter int unsigned AF_THRESH   = FIFO_DEPTH - 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             write_en,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic [DELAY_WIDTH-1:0]           delay_in,
    input  logic                             read_en,
    input  logic                             clear_err,
    output logic                             rd_ready,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             data_out_valid,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic [cnt_width(FIFO_DEPTH)-1:0] count,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
    localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

    logic [DELAY_WIDTH-1:0] r_ts;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_empty;
    logic                   r_full;
    logic                   r_af;
    logic [ERR_W-1:0]       r_err;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic                   r_dv;
    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];

    logic [FIFO_DEPTH-1:0]  w_ready;
    logic                   w_rd_ready;
    logic                   w_rd_acc;
    logic                   w_wr_acc;
    logic [CNT_W-1:0]       w_count_nxt;
    logic [ERR_W-1:0]       w_err_nxt;

    // Only the head slot decides readiness; matured younger words wait behind it.
    assign w_rd_ready = ~r_empty & w_ready[r_rd_ptr];
    assign w_rd_acc   = read_en & w_rd_ready;
    assign w_wr_acc   = write_en & (~r_full | w_rd_acc);

    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_slot
        fifo_entry_timer #(
            .DELAY_WIDTH (DELAY_WIDTH)
        ) u_timer (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_ts      (r_ts),
            .i_wr      (w_wr_acc && (r_wr_ptr == PTR_W'(i))),
            .i_delay   (delay_in),
            .i_pop     (w_rd_acc && (r_rd_ptr == PTR_W'(i))),
            .o_ready_c (w_ready[i])
        );
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Clear wins over any same-cycle error event.
    always_comb begin
        w_err_nxt = r_err;
        if (clear_err) begin
            w_err_nxt = '0;
        end else begin
            if (write_en && r_full && !w_rd_acc) w_err_nxt[ERR_OVF] = 1'b1;
            if (read_en && !w_rd_ready)          w_err_nxt[ERR_UDF] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_err    <= '0;
            r_dout   <= '0;
            r_dv     <= 1'b0;
        end else begin
            r_ts    <= r_ts + DELAY_WIDTH'(1);
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            r_af    <= (w_count_nxt >= CNT_W'(AF_THRESH));
            r_err   <= w_err_nxt;
            r_dv    <= w_rd_acc;
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_dout   <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= data_in;
    end

    assign rd_ready       = w_rd_ready;
    assign data_out       = r_dout;
    assign data_out_valid = r_dv;
    assign full           = r_full;
    assign empty          = r_empty;
    assign almost_full    = r_af;
    assign count          = r_count;
    assign overflow       = r_err[ERR_OVF];
    assign underflow      = r_err[ERR_UDF];

endmodule
